// File: rtl/mlp_frame_sequencer_if.sv
// Feature-in / class-out valid/ready stream bundle for mlp_frame_sequencer.
// master is the producer/consumer side (testbench or host), slave is the sequencer.
interface mlp_frame_sequencer_if #(
    parameter int FEAT_W = 4,
    parameter int CLS_W  = 2
);
    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [CLS_W-1:0]  m_class;
    logic              m_err;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class, m_err
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class, m_err
    );
endinterface

// File: rtl/mlp_frame_sequencer.sv
// Packs serial features into the flat input of a slow combinational MLP, holds it
// for SETTLE cycles, then returns the captured class on a valid/ready stream.
module mlp_frame_sequencer #(
    parameter int FEAT_W = 4,
    parameter int N_FEAT = 4,
    parameter int CLS_W  = 2,
    parameter int SETTLE = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    mlp_frame_sequencer_if.slave     bus,
    output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
    input  logic [CLS_W-1:0]         mlp_out,
    output logic [7:0]               drop_cnt,
    output logic                     busy
);
    localparam int            KW          = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [KW-1:0] K_LAST      = KW'(N_FEAT - 1);
    localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE);

    typedef enum logic [1:0] {ST_COLLECT, ST_SETTLE, ST_HOLD} state_t;

    typedef struct packed {
        logic             err;
        logic [CLS_W-1:0] cls;
    } result_t;

    state_t                        state, state_nxt;
    logic [KW-1:0]                 k;
    logic [N_FEAT-2:0][FEAT_W-1:0] shadow;
    logic [7:0]                    settle_cnt;
    logic                          err_pend;
    result_t                       res;

    logic s_ready_int;
    logic s_xfer;
    logic frame_done;
    logic frame_abort;
    logic settle_done;

    assign s_xfer      = bus.s_valid && s_ready_int;
    assign frame_done  = s_xfer && (k == K_LAST);
    assign frame_abort = s_xfer && (k != K_LAST) && bus.s_last;
    assign settle_done = (state == ST_SETTLE) && (settle_cnt == 8'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (frame_done)  state_nxt = ST_SETTLE;
            ST_SETTLE:  if (settle_done) state_nxt = ST_HOLD;
            ST_HOLD:    if (bus.m_ready) state_nxt = ST_COLLECT;
            default:                     state_nxt = ST_COLLECT;
        endcase
    end

    // s_ready drops combinationally with rst so nothing is accepted during reset.
    always_comb begin
        s_ready_int = (state == ST_COLLECT) && !rst;
        bus.m_valid = (state == ST_HOLD);
        busy        = (state != ST_COLLECT);
    end

    assign bus.s_ready = s_ready_int;
    assign bus.m_class = res.cls;
    assign bus.m_err   = res.err;

    // One shadow slot per non-final feature; the final feature goes straight to mlp_inp.
    for (genvar i = 0; i < N_FEAT - 1; i++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst || frame_abort)
                shadow[i] <= '0;
            else if (s_xfer && (k == KW'(i)))
                shadow[i] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            mlp_inp  <= '0;
            err_pend <= 1'b0;
        end else if (frame_done) begin
            k        <= '0;
            mlp_inp  <= {bus.s_data, shadow};
            err_pend <= !bus.s_last;
        end else if (frame_abort) begin
            k        <= '0;
        end else if (s_xfer) begin
            k        <= k + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (frame_abort && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            settle_cnt <= '0;
        else if (frame_done)
            settle_cnt <= SETTLE_INIT;
        else if (state == ST_SETTLE)
            settle_cnt <= settle_cnt - 8'd1;
    end

    // Result registers only move on the settle-expiry cycle, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst)
            res <= '0;
        else if (settle_done)
            res <= '{err: err_pend, cls: mlp_out};
    end
endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Self-checking bench: frame vector table, hand-written corner sequences, and a
// randomized run compared against a frame-level packing/classification model.
module tb_mlp_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stand-in classifier: (sum of the four nibbles + 3) mod 4.
    function automatic logic [1:0] cls(input logic [15:0] v);
        int s;
        s = int'(v[3:0]) + int'(v[7:4]) + int'(v[11:8]) + int'(v[15:12]) + 3;
        return s[1:0];
    endfunction

    mlp_frame_sequencer_if #(.FEAT_W(4), .CLS_W(2)) ifa ();
    mlp_frame_sequencer_if #(.FEAT_W(4), .CLS_W(2)) ifb ();

    logic [15:0] inp_a, inp_b;
    logic [1:0]  out_a, out_b;
    logic [7:0]  drop_a, drop_b;
    logic        busy_a, busy_b;

    assign out_a = cls(inp_a);
    assign out_b = cls(inp_b);

    mlp_frame_sequencer #(.FEAT_W(4), .N_FEAT(4), .CLS_W(2), .SETTLE(3)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .mlp_inp(inp_a), .mlp_out(out_a),
        .drop_cnt(drop_a), .busy(busy_a));

    mlp_frame_sequencer #(.FEAT_W(4), .N_FEAT(4), .CLS_W(2), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .mlp_inp(inp_b), .mlp_out(out_b),
        .drop_cnt(drop_b), .busy(busy_b));

    typedef struct {
        logic [3:0]  f [4];
        logic        last4;
        logic [15:0] exp_inp;
        logic [1:0]  exp_cls;
        logic        exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] d, input logic l);
        bit done;
        done = 1'b0;
        ifa.s_valid = 1'b1;
        ifa.s_data  = d;
        ifa.s_last  = l;
        for (int i = 0; i < 40 && !done; i++) begin
            if (ifa.s_ready) done = 1'b1;
            tick();
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        ifa.s_valid = 1'b0;
        ifa.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] f0, input logic [3:0] f1, input logic [3:0] f2,
                              input logic [3:0] f3, input logic l3, input int gap_max);
        logic [3:0] f [4];
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            send_a(f[j], (j == 3) ? l3 : 1'b0);
        end
    endtask

    // Called in the cycle right after the final feature transfer.
    task automatic get_a(input string tag, input int delay, input logic [1:0] ec,
                         input logic ee, input int elat);
        int lat;
        lat = 0;
        while (!ifa.m_valid && lat < 30) begin
            tick();
            lat++;
        end
        chk({tag, "_valid"}, ifa.m_valid, 1);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_cls"}, ifa.m_class, ec);
        chk({tag, "_err"}, ifa.m_err, ee);
        ifa.m_ready = 1'b0;
        repeat (delay) begin
            tick();
            chk({tag, "_hold_valid"}, ifa.m_valid, 1);
            chk({tag, "_hold_cls"}, ifa.m_class, ec);
        end
        ifa.m_ready = 1'b1;
        tick();
        ifa.m_ready = 1'b0;
        chk({tag, "_after_valid"}, ifa.m_valid, 0);
        chk({tag, "_after_ready"}, ifa.s_ready, 1);
    endtask

    task automatic set_vec(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic l, input logic [15:0] inp,
                           input logic [1:0] k, input logic e);
        tbl[i].f[0] = a; tbl[i].f[1] = b; tbl[i].f[2] = c; tbl[i].f[3] = d;
        tbl[i].last4 = l; tbl[i].exp_inp = inp; tbl[i].exp_cls = k; tbl[i].exp_err = e;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        seen;
        logic [3:0]  fb [4];
        logic [3:0]  rf [4];
        logic [15:0] exp_inp, last_inp;
        logic        l3;
        int          drops, kind, len, sum;

        ifa.s_valid = 0; ifa.s_data = 0; ifa.s_last = 0; ifa.m_ready = 0;
        ifb.s_valid = 0; ifb.s_data = 0; ifb.s_last = 0; ifb.m_ready = 0;

        set_vec(0, 4'h5, 4'h6, 4'h3, 4'h1, 1'b1, 16'h1365, 2'd2, 1'b0);
        set_vec(1, 4'h9, 4'h9, 4'h9, 4'h9, 1'b0, 16'h9999, 2'd3, 1'b1);
        set_vec(2, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 16'h4321, 2'd1, 1'b0);
        set_vec(3, 4'hF, 4'h0, 4'hA, 4'h5, 1'b1, 16'h5A0F, 2'd1, 1'b0);
        set_vec(4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 2'd3, 1'b1);
        set_vec(5, 4'h8, 4'h4, 4'h2, 4'h1, 1'b1, 16'h1248, 2'd2, 1'b0);

        // Reset state
        tick(); tick();
        chk("rst_s_ready", ifa.s_ready, 0);
        chk("rst_m_valid", ifa.m_valid, 0);
        chk("rst_inp", inp_a, 16'h0);
        chk("rst_drop", drop_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_class", ifa.m_class, 0);
        chk("rst_err", ifa.m_err, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ifa.s_ready, 1);

        // Clean frame with exact latency, then backpressure
        send_a(4'h5, 0); send_a(4'h6, 0); send_a(4'h3, 0); send_a(4'h1, 1);
        chk("clean_inp_t1", inp_a, 16'h1365);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            chk($sformatf("clean_s_ready_t%0d", c), ifa.s_ready, 0);
            chk($sformatf("clean_m_valid_t%0d", c), ifa.m_valid, (c == 4) ? 1 : 0);
        end
        chk("clean_cls", ifa.m_class, 2);
        chk("clean_err", ifa.m_err, 0);
        chk("clean_busy", busy_a, 1);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("bp_valid", ifa.m_valid, 1);
            chk("bp_cls", ifa.m_class, 2);
            chk("bp_inp", inp_a, 16'h1365);
            chk("bp_s_ready", ifa.s_ready, 0);
        end
        ifa.m_ready = 1'b1;
        tick();
        ifa.m_ready = 1'b0;
        chk("bp_release_valid", ifa.m_valid, 0);
        chk("bp_release_ready", ifa.s_ready, 1);
        chk("bp_release_busy", busy_a, 0);
        chk("bp_release_inp", inp_a, 16'h1365);

        // Early last aborts and counts, then a clean frame gives the only result
        send_a(4'h7, 0); send_a(4'h2, 1);
        chk("el_drop", drop_a, 1);
        chk("el_inp_kept", inp_a, 16'h1365);
        chk("el_no_valid", ifa.m_valid, 0);
        chk("el_busy", busy_a, 0);
        send_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 0);
        chk("el_inp", inp_a, 16'h4321);
        get_a("el", 0, 2'd1, 1'b0, 3);
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (ifa.m_valid) seen = 1'b1;
        end
        chk("el_single_result", seen, 0);

        // Table frames (missing-last followed by a clean frame included)
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].f[0], tbl[i].f[1], tbl[i].f[2], tbl[i].f[3], tbl[i].last4, 2);
            chk($sformatf("tbl%0d_inp", i), inp_a, tbl[i].exp_inp);
            get_a($sformatf("tbl%0d", i), i % 3, tbl[i].exp_cls, tbl[i].exp_err, 3);
        end
        chk("tbl_drop_unchanged", drop_a, 1);

        // Gapped input on the SETTLE=1 instance
        fb[0] = 4'hA; fb[1] = 4'hB; fb[2] = 4'hC; fb[3] = 4'hD;
        for (int i = 0; i < 4; i++) begin
            ifb.s_valid = 1'b1; ifb.s_data = fb[i]; ifb.s_last = (i == 3);
            chk("gap_s_ready", ifb.s_ready, 1);
            tick();
            ifb.s_valid = 1'b0; ifb.s_last = 1'b0;
            if (i < 3) begin
                tick();
                chk("gap_idle_inp", inp_b, 16'h0);
            end
        end
        chk("gap_inp", inp_b, 16'hDCBA);
        chk("gap_t1_valid", ifb.m_valid, 0);
        tick();
        chk("gap_t2_valid", ifb.m_valid, 1);
        chk("gap_cls", ifb.m_class, 2'd1);
        chk("gap_err", ifb.m_err, 0);
        ifb.m_ready = 1'b1;
        tick();
        ifb.m_ready = 1'b0;
        chk("gap_release", ifb.m_valid, 0);

        // Reset in SETTLE discards the frame
        send_frame(4'h8, 4'h7, 4'h6, 4'h5, 1'b1, 0);
        chk("rs_busy", busy_a, 1);
        rst = 1'b1;
        tick();
        chk("rs_s_ready_in_rst", ifa.s_ready, 0);
        chk("rs_m_valid", ifa.m_valid, 0);
        chk("rs_inp", inp_a, 16'h0);
        chk("rs_drop", drop_a, 0);
        rst = 1'b0;
        tick();
        chk("rs_s_ready_after", ifa.s_ready, 1);
        chk("rs_m_valid_after", ifa.m_valid, 0);
        chk("rs_inp_after", inp_a, 16'h0);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (ifa.m_valid) seen = 1'b1;
        end
        chk("rs_no_stale", seen, 0);

        // drop_cnt saturation
        for (int i = 0; i < 260; i++) begin
            send_a(4'(i), 1'b1);
            if (i == 0)   chk("sat_first", drop_a, 1);
            if (i == 254) chk("sat_255", drop_a, 255);
        end
        chk("sat_hold", drop_a, 255);
        chk("sat_no_valid", ifa.m_valid, 0);

        // Randomized frames against a frame-level model
        rst = 1'b1; tick(); rst = 1'b0;
        drops = 0;
        last_inp = 16'h0;
        repeat (60) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_a(4'($urandom), j == len - 1);
                end
                drops = (drops < 255) ? drops + 1 : 255;
                chk("rnd_drop", drop_a, drops);
                chk("rnd_abort_inp", inp_a, last_inp);
                chk("rnd_abort_valid", ifa.m_valid, 0);
            end else begin
                for (int j = 0; j < 4; j++) rf[j] = 4'($urandom);
                l3 = ($urandom_range(0, 3) != 0);
                send_frame(rf[0], rf[1], rf[2], rf[3], l3, 2);
                exp_inp = 16'h0;
                sum = 3;
                for (int j = 0; j < 4; j++) begin
                    exp_inp = exp_inp | (16'(rf[j]) << (4 * j));
                    sum += int'(rf[j]);
                end
                chk("rnd_inp", inp_a, exp_inp);
                get_a("rnd", $urandom_range(0, 3), 2'(sum % 4), !l3, 3);
                last_inp = exp_inp;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mlp_frame_sequencer.md
Name: mlp_frame_sequencer

Overview:
- Driver/collector for the bespoke combinational MLP classifiers, e.g. the Iris classifier with 4 features x 4 bits in and a 2-bit class out.
- Accepts features serially over a valid/ready stream and packs them into the classifier's flat input vector.
- Holds that vector stable for a programmable settle time, because printed combinational logic is slow.
- Captures the class index and returns it on a valid/ready result stream, with framing status.

Parameters:
- FEAT_W, 4: bits per feature.
- N_FEAT, 4: features per frame.
- CLS_W, 2: class index width.
- SETTLE, 3: full cycles mlp_inp is held stable before mlp_out is sampled. Legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  feature valid.
- s_ready  out  1  feature ready.
- s_data  in  FEAT_W  feature value, unsigned.
- s_last  in  1  marks the final feature of a frame.
- mlp_inp  out  N_FEAT*FEAT_W  packed vector to the classifier, registered.
- mlp_out  in  CLS_W  class index from the classifier, combinational.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_class  out  CLS_W  captured class.
- m_err  out  1  result frame lacked s_last on its final feature.
- drop_cnt  out  8  count of aborted frames, saturating.
- busy  out  1  high when state is not COLLECT.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to COLLECT; feature index k=0.
  - mlp_inp, the shadow vector, m_class, m_err and drop_cnt all go to 0.
  - m_valid=0, busy=0.
  - s_ready is forced to 0 while rst=1.
  - Reset in any state discards the frame or result in flight; no partial output.
- Handshakes:
  - A transfer occurs on a cycle where valid&&ready.
  - s_data and s_last are sampled only on a transfer.
  - m_class and m_err stay stable while m_valid=1 && m_ready=0.
- s_ready is combinational: 1 in COLLECT when rst=0, otherwise 0.
- COLLECT, on a feature transfer:
  - Feature k is written to shadow bits [k*FEAT_W+FEAT_W-1 : k*FEAT_W]. Feature 0 lands at the LSBs.
  - k<N_FEAT-1 and s_last=0: k increments.
  - k<N_FEAT-1 and s_last=1 (early last):
    - The frame is aborted; shadow is cleared and k=0.
    - drop_cnt increments, saturating at 255.
    - mlp_inp is unchanged; state stays COLLECT.
  - k==N_FEAT-1:
    - mlp_inp loads {this feature, shadow upper-aligned}, i.e. the full packed frame.
    - The pending error flag is set to !s_last.
    - k=0; settle counter = SETTLE; state goes to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - On the cycle the counter equals 1:
    - mlp_out is captured into m_class and the pending flag into m_err.
    - m_valid goes to 1 on the next cycle; state goes to HOLD.
  - Latency: final feature transfer in cycle T. New mlp_inp is visible from T+1, mlp_out is sampled at the end of T+SETTLE, and m_valid is first high in T+SETTLE+1.
  - Default SETTLE=3 gives m_valid in T+4.
- HOLD:
  - m_valid=1 and s_ready=0.
  - On the m_ready transfer, m_valid goes to 0 the next cycle and state goes to COLLECT. s_ready is 1 in that following cycle; there is no back-to-back overlap.
- mlp_inp changes only at a full-frame load or at reset. It holds its value through SETTLE, HOLD and the next COLLECT.
- Idle cycles (s_valid=0) inside a frame are allowed and have no effect.
- busy=1 in SETTLE and HOLD.
- Widths: all counters are unsigned. k is clog2(N_FEAT) bits; the settle counter is 8 bits. No arithmetic on data.

Test Plan:
- Clean frame, defaults:
  - Stimulus: features 5,6,3,1 with s_last on the 4th; classifier model drives mlp_out=2'b10.
  - Required: mlp_inp=16'h1365 from T+1; m_valid first high in T+4; m_class=2, m_err=0; s_ready=0 through T+1..T+4.
- Backpressure:
  - Stimulus: clean frame, then m_ready held 0 for 6 cycles after m_valid rises.
  - Required: m_valid, m_class and mlp_inp stable, s_ready=0 throughout; on the m_ready=1 cycle, m_valid=0 and s_ready=1 the next cycle.
- Early last:
  - Stimulus: features 7,2 with s_last on the 2nd; then 1,2,3,4 with s_last on the 4th.
  - Required: drop_cnt=1; only one result; mlp_inp=16'h4321; m_err=0.
- Missing last:
  - Stimulus: 4 features 9,9,9,9, all with s_last=0.
  - Required: mlp_inp=16'h9999; result with m_err=1; the next clean frame has m_err=0.
- Gapped input and SETTLE=1:
  - Stimulus: s_valid toggling 1/0 across a frame, with SETTLE=1.
  - Required: correct packing; m_valid high in T+2 after the final transfer.
- Reset mid-SETTLE, plus drop_cnt saturation:
  - Stimulus: rst asserted 1 cycle in SETTLE; separately, 260 early-last frames.
  - Required: after reset, m_valid=0, mlp_inp=0, s_ready=1 the cycle after rst deasserts, and no stale result. drop_cnt holds at 255.
